// File: rtl/text_console_pkg.sv
// Shared definitions for the text console writer: tram word layout,
// control code points and the writer FSM state encoding.
package text_console_pkg;

  localparam int CPW    = 21;
  localparam int FG_LSB = 28;
  localparam int BG_LSB = 24;
  localparam int CP_LSB = 0;

  localparam logic [CPW-1:0] CP_BLANK = 21'h20;
  localparam logic [CPW-1:0] CP_LF    = 21'h0A;
  localparam logic [CPW-1:0] CP_CR    = 21'h0D;
  localparam logic [CPW-1:0] CP_BS    = 21'h08;
  localparam logic [CPW-1:0] CP_TAB   = 21'h09;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUT,
    S_LF,
    S_CLR_LINE,
    S_CLS
  } state_t;

endpackage

// File: rtl/text_console.sv
// Terminal writer: accepts a code-point stream, tracks the cursor, writes glyph
// words into tram and scrolls by treating tram as a ring of text lines.
module text_console
  import text_console_pkg::*;
#(
  parameter int WORD      = 32,
  parameter int BYTE_CNT  = 4,
  parameter int ADDRW     = 11,
  parameter int CIDXW     = 4,
  parameter int TEXT_HRES = 84,
  parameter int TEXT_VRES = 24
) (
  input  logic                clk_sys,
  input  logic                rst_sys,
  input  logic                ch_valid,
  output logic                ch_ready,
  input  logic [CPW-1:0]      ch_data,
  input  logic [CIDXW-1:0]    fg,
  input  logic [CIDXW-1:0]    bg,
  input  logic                cls,
  output logic [BYTE_CNT-1:0] tram_we,
  output logic [ADDRW-1:0]    tram_addr,
  output logic [WORD-1:0]     tram_din,
  output logic [ADDRW-1:0]    scroll_offs,
  output logic [ADDRW-1:0]    cur_x,
  output logic [ADDRW-1:0]    cur_y,
  output logic                busy
);

  localparam logic [ADDRW-1:0] LAST_COL  = ADDRW'(TEXT_HRES - 1);
  localparam logic [ADDRW-1:0] LAST_ROW  = ADDRW'(TEXT_VRES - 1);
  localparam logic [ADDRW-1:0] ROW_STEP  = ADDRW'(TEXT_HRES);
  localparam logic [ADDRW-1:0] LAST_BASE = ADDRW'((TEXT_VRES - 1) * TEXT_HRES);
  localparam logic [ADDRW-1:0] LAST_CELL = ADDRW'(TEXT_HRES * TEXT_VRES - 1);
  localparam logic [ADDRW-1:0] TAB_MASK  = ADDRW'(7);

  state_t               state, state_n;
  logic [ADDRW-1:0]     cur_x_n, cur_y_n;
  logic [ADDRW-1:0]     cur_base, cur_base_n;  // tram address of the cursor's row
  logic [ADDRW-1:0]     top_base, top_base_n;  // tram address of the top screen row
  logic [ADDRW-1:0]     idx, idx_n;
  logic [CIDXW-1:0]     fg_q, fg_n, bg_q, bg_n;
  logic [BYTE_CNT-1:0]  we_n;
  logic [ADDRW-1:0]     addr_n;
  logic [WORD-1:0]      din_n;
  logic [ADDRW-1:0]     tab_x;

  function automatic logic [WORD-1:0] make_word(input logic [CIDXW-1:0] f,
                                                input logic [CIDXW-1:0] b,
                                                input logic [CPW-1:0]   cp);
    logic [WORD-1:0] w;
    w = '0;
    w[FG_LSB +: CIDXW] = f;
    w[BG_LSB +: CIDXW] = b;
    w[CP_LSB +: CPW]   = cp;
    return w;
  endfunction

  // Row bases step by one line and wrap explicitly, avoiding any multiply or mod.
  function automatic logic [ADDRW-1:0] next_base(input logic [ADDRW-1:0] b);
    return (b == LAST_BASE) ? '0 : b + ROW_STEP;
  endfunction

  assign tab_x       = (cur_x | TAB_MASK) + 1'b1;
  assign scroll_offs = top_base;
  assign busy        = (state != S_IDLE);
  assign ch_ready    = (state == S_IDLE) && !cls;

  // The tram outputs are loaded one state ahead, so the write belonging to a
  // state is on the port during that state's cycle.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    state_n    = state;
    cur_x_n    = cur_x;
    cur_y_n    = cur_y;
    cur_base_n = cur_base;
    top_base_n = top_base;
    idx_n      = idx;
    fg_n       = fg_q;
    bg_n       = bg_q;
    we_n       = '0;
    addr_n     = tram_addr;
    din_n      = tram_din;

    case (state)
      S_IDLE: begin
        if (cls) begin
          state_n = S_CLS;
          idx_n   = '0;
          we_n    = '1;
          addr_n  = '0;
          din_n   = make_word(fg_q, bg_q, CP_BLANK);
        end else if (ch_valid) begin
          fg_n = fg;
          bg_n = bg;
          if (ch_data >= CP_BLANK) begin
            state_n = S_PUT;
            we_n    = '1;
            addr_n  = cur_base + cur_x;
            din_n   = make_word(fg, bg, ch_data);
          end else begin
            case (ch_data)
              CP_LF:  state_n = S_LF;
              CP_CR:  cur_x_n = '0;
              CP_BS:  if (cur_x != '0) cur_x_n = cur_x - 1'b1;
              CP_TAB: cur_x_n = (tab_x > LAST_COL) ? LAST_COL : tab_x;
              default: ;
            endcase
          end
        end
      end

      S_PUT: begin
        if (cur_x == LAST_COL) begin
          cur_x_n = '0;
          state_n = S_LF;
        end else begin
          cur_x_n = cur_x + 1'b1;
          state_n = S_IDLE;
        end
      end

      S_LF: begin
        cur_x_n = '0;
        if (cur_y != LAST_ROW) begin
          cur_y_n    = cur_y + 1'b1;
          cur_base_n = next_base(cur_base);
          state_n    = S_IDLE;
        end else begin
          state_n = S_CLR_LINE;
          idx_n   = '0;
          we_n    = '1;
          addr_n  = top_base;
          din_n   = make_word(fg_q, bg_q, CP_BLANK);
        end
      end

      // The old top line becomes the new bottom; scroll only once it is blank.
      S_CLR_LINE: begin
        if (idx == LAST_COL) begin
          top_base_n = next_base(top_base);
          cur_base_n = next_base(cur_base);
          state_n    = S_IDLE;
        end else begin
          idx_n  = idx + 1'b1;
          we_n   = '1;
          addr_n = tram_addr + 1'b1;
        end
      end

      S_CLS: begin
        if (idx == LAST_CELL) begin
          top_base_n = '0;
          cur_base_n = '0;
          cur_x_n    = '0;
          cur_y_n    = '0;
          state_n    = S_IDLE;
        end else begin
          idx_n  = idx + 1'b1;
          we_n   = '1;
          addr_n = tram_addr + 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state     <= S_IDLE;
      cur_x     <= '0;
      cur_y     <= '0;
      cur_base  <= '0;
      top_base  <= '0;
      idx       <= '0;
      fg_q      <= '1;
      bg_q      <= '0;
      tram_we   <= '0;
      tram_addr <= '0;
      tram_din  <= '0;
    end else begin
      state     <= state_n;
      cur_x     <= cur_x_n;
      cur_y     <= cur_y_n;
      cur_base  <= cur_base_n;
      top_base  <= top_base_n;
      idx       <= idx_n;
      fg_q      <= fg_n;
      bg_q      <= bg_n;
      tram_we   <= we_n;
      tram_addr <= addr_n;
      tram_din  <= din_n;
    end
  end

endmodule
